// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the 64-point radix-2 FFT sequencer.
package fft_pkg;

  localparam int FFT_LOG2N  = 6;
  localparam int FFT_N      = 64;
  localparam int N_BFLY     = 32;
  localparam int LAST_LEVEL = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PROC  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } fft_state_t;

  // Status flags that depend only on the state being entered; they are
  // registered together with the state so the outputs come straight from flops.
  typedef struct packed {
    logic load;
    logic processing;
    logic done;
    logic busy;
    logic rd_valid;
  } fft_flags_t;

  function automatic fft_flags_t state_flags(input fft_state_t s);
    fft_flags_t f;
    f = '0;
    case (s)
      IDLE: f = '0;
      LOAD: begin
        f.load = 1'b1;
        f.busy = 1'b1;
      end
      PROC: begin
        f.processing = 1'b1;
        f.busy       = 1'b1;
        f.rd_valid   = 1'b1;
      end
      DRAIN: begin
        f.processing = 1'b1;
        f.busy       = 1'b1;
      end
      OUT: begin
        f.done = 1'b1;
        f.busy = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// Control/status bundle between the FFT sequencer (master) and the
// address generator / data path side (slave).
interface fft_ctrl_if;

  logic       start;
  logic       sample_valid;
  logic       load;
  logic       processing;
  logic       done;
  logic       busy;
  logic [5:0] load_address;
  logic       load_we;
  logic [5:0] fft_level;
  logic [5:0] butterfly_iter;
  logic       rd_valid;
  logic [5:0] wr_fft_level;
  logic [5:0] wr_butterfly_iter;
  logic       wr_en;
  logic       bank_sel;
  logic       wr_bank_sel;
  logic [5:0] out_address;
  logic       out_valid;
  logic       fft_done;

  modport master (
    input  start, sample_valid,
    output load, processing, done, busy, load_address, load_we,
           fft_level, butterfly_iter, rd_valid,
           wr_fft_level, wr_butterfly_iter, wr_en,
           bank_sel, wr_bank_sel, out_address, out_valid, fft_done
  );

  modport slave (
    output start, sample_valid,
    input  load, processing, done, busy, load_address, load_we,
           fft_level, butterfly_iter, rd_valid,
           wr_fft_level, wr_butterfly_iter, wr_en,
           bank_sel, wr_bank_sel, out_address, out_valid, fft_done
  );

endinterface

// File: rtl/fft_ctrl_delay_line.sv
// Fixed-depth register pipeline; used to align read-side butterfly indices
// with the write-back of the same butterfly.
module delay_line #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; reset clears all stages so no stale write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// Top-level sequencer for the 64-point in-place FFT:
// LOAD -> 6 x (PROC 32 butterflies, DRAIN BFLY_LAT cycles) -> OUT.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned BFLY_LAT = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  fft_ctrl_if.master   bus
);

  fft_state_t state_q;
  fft_flags_t flags_q;
  logic [5:0] load_address_q;
  logic [5:0] fft_level_q;
  logic [5:0] butterfly_iter_q;
  logic [2:0] drain_cnt_q;
  logic [5:0] out_address_q;
  logic       out_valid_q;
  logic       fft_done_q;
  logic [12:0] wb_in_s;
  logic [12:0] wb_out_s;

  // Main sequencer: state, counters and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      flags_q          <= '0;
      load_address_q   <= 6'd0;
      fft_level_q      <= 6'd0;
      butterfly_iter_q <= 6'd0;
      drain_cnt_q      <= 3'd0;
      out_address_q    <= 6'd0;
      out_valid_q      <= 1'b0;
      fft_done_q       <= 1'b0;
    end else begin
      fft_done_q  <= 1'b0;
      // Synchronous output RAM: data for the address shown now is valid next cycle.
      out_valid_q <= (state_q == OUT);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q        <= LOAD;
            flags_q        <= state_flags(LOAD);
            load_address_q <= 6'd0;
          end
        end
        LOAD: begin
          if (bus.sample_valid) begin
            if (load_address_q == 6'(FFT_N - 1)) begin
              state_q          <= PROC;
              flags_q          <= state_flags(PROC);
              load_address_q   <= 6'd0;
              fft_level_q      <= 6'd0;
              butterfly_iter_q <= 6'd0;
            end else begin
              load_address_q <= load_address_q + 6'd1;
            end
          end
        end
        PROC: begin
          if (butterfly_iter_q == 6'(N_BFLY - 1)) begin
            state_q          <= DRAIN;
            flags_q          <= state_flags(DRAIN);
            butterfly_iter_q <= 6'd0;
            drain_cnt_q      <= 3'd0;
          end else begin
            butterfly_iter_q <= butterfly_iter_q + 6'd1;
          end
        end
        DRAIN: begin
          // Hold reads off until every write of this level has landed.
          if (drain_cnt_q == 3'(BFLY_LAT - 1)) begin
            drain_cnt_q <= 3'd0;
            if (fft_level_q == 6'(LAST_LEVEL)) begin
              // Odd last level wrote bank 0; point the read bank back there.
              state_q       <= OUT;
              flags_q       <= state_flags(OUT);
              out_address_q <= 6'd0;
              fft_level_q   <= 6'd0;
            end else begin
              state_q     <= PROC;
              flags_q     <= state_flags(PROC);
              fft_level_q <= fft_level_q + 6'd1;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 3'd1;
          end
        end
        OUT: begin
          if (out_address_q == 6'(FFT_N - 1)) begin
            state_q       <= IDLE;
            flags_q       <= state_flags(IDLE);
            out_address_q <= 6'd0;
            fft_done_q    <= 1'b1;
          end else begin
            out_address_q <= out_address_q + 6'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          flags_q <= state_flags(IDLE);
        end
      endcase
    end
  end

  assign wb_in_s = {flags_q.rd_valid, fft_level_q, butterfly_iter_q};

  delay_line #(
    .WIDTH (13),
    .DEPTH (int'(BFLY_LAT))
  ) u_wb_pipe (
    .clk    (clk),
    .rst_n  (reset_n),
    .din_i  (wb_in_s),
    .dout_o (wb_out_s)
  );

  assign bus.load              = flags_q.load;
  assign bus.processing        = flags_q.processing;
  assign bus.done              = flags_q.done;
  assign bus.busy              = flags_q.busy;
  assign bus.rd_valid          = flags_q.rd_valid;
  assign bus.load_address      = load_address_q;
  assign bus.load_we           = flags_q.load & bus.sample_valid;
  assign bus.fft_level         = fft_level_q;
  assign bus.butterfly_iter    = butterfly_iter_q;
  assign bus.bank_sel          = fft_level_q[0];
  assign bus.wr_en             = wb_out_s[12];
  assign bus.wr_fft_level      = wb_out_s[11:6];
  assign bus.wr_butterfly_iter = wb_out_s[5:0];
  assign bus.wr_bank_sel       = wb_out_s[6];
  assign bus.out_address       = out_address_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.fft_done          = fft_done_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: scenario table plus scoreboard queues.
module tb_fft_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  fft_ctrl_if bus();

  fft_ctrl #(.BFLY_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit toggle;
    bit start_mid;
    int exp_load_cycles;
    int exp_lat;
  } vec_t;

  typedef struct {
    int due;
    int lvl;
    int it;
  } wr_t;

  int  n_vec  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  n_done = 0;
  int  prev_done = 0;
  int  prev_addr = 0;
  int  exp_load[$];
  int  exp_rd[$];
  int  exp_out[$];
  wr_t wr_q[$];
  int  bank_log[$];
  vec_t vectors[3];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    int  e;
    cyc++;
    if (reset_n) begin
      if (bus.load_we) begin
        if (exp_load.size() == 0) chk("load_extra", 1, 0);
        else chk("load_addr", bus.load_address, exp_load.pop_front());
      end
      if (bus.rd_valid) begin
        if (bus.butterfly_iter == 6'd0) begin
          bank_log.push_back(int'(bus.bank_sel));
          if (bus.fft_level != 6'd0) chk("rd_before_wb", wr_q.size(), 0);
        end
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_level", bus.fft_level, e / 32);
          chk("rd_iter", bus.butterfly_iter, e % 32);
        end
        chk("bank_sel", bus.bank_sel, bus.fft_level % 2);
        wr_q.push_back('{cyc + LAT, int'(bus.fft_level), int'(bus.butterfly_iter)});
      end
      if (bus.wr_en) begin
        chk("wr_in_proc", bus.processing, 1);
        if (wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_time", cyc, w.due);
          chk("wr_level", bus.wr_fft_level, w.lvl);
          chk("wr_iter", bus.wr_butterfly_iter, w.it);
          chk("wr_bank", bus.wr_bank_sel, w.lvl % 2);
        end
      end
      if (bus.done) begin
        if (exp_out.size() == 0) chk("out_extra", 1, 0);
        else chk("out_addr", bus.out_address, exp_out.pop_front());
      end
      if (bus.out_valid || prev_done != 0) chk("out_valid_lag", bus.out_valid, prev_done);
      if (bus.fft_done) begin
        n_done++;
        chk("done_after_63", prev_addr, 63);
        chk("done_state_low", bus.done, 0);
        chk("done_busy_low", bus.busy, 0);
      end
      prev_done = int'(bus.done);
      prev_addr = int'(bus.out_address);
    end else begin
      prev_done = 0;
      prev_addr = 0;
    end
  end

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_load"}, bus.load, 0);
    chk({pfx, "_processing"}, bus.processing, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_load_address"}, bus.load_address, 0);
    chk({pfx, "_load_we"}, bus.load_we, 0);
    chk({pfx, "_fft_level"}, bus.fft_level, 0);
    chk({pfx, "_iter"}, bus.butterfly_iter, 0);
    chk({pfx, "_rd_valid"}, bus.rd_valid, 0);
    chk({pfx, "_wr_level"}, bus.wr_fft_level, 0);
    chk({pfx, "_wr_iter"}, bus.wr_butterfly_iter, 0);
    chk({pfx, "_wr_en"}, bus.wr_en, 0);
    chk({pfx, "_bank_sel"}, bus.bank_sel, 0);
    chk({pfx, "_wr_bank_sel"}, bus.wr_bank_sel, 0);
    chk({pfx, "_out_address"}, bus.out_address, 0);
    chk({pfx, "_out_valid"}, bus.out_valid, 0);
    chk({pfx, "_fft_done"}, bus.fft_done, 0);
  endtask

  task automatic flush_sb();
    exp_load.delete();
    exp_rd.delete();
    exp_out.delete();
    wr_q.delete();
    bank_log.delete();
  endtask

  task automatic fill_sb();
    flush_sb();
    n_done = 0;
    for (int i = 0; i < 64; i++) exp_load.push_back(i);
    for (int l = 0; l < 6; l++)
      for (int i = 0; i < 32; i++) exp_rd.push_back(l * 32 + i);
    for (int i = 0; i < 64; i++) exp_out.push_back(i);
  endtask

  task automatic start_pulse();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_load", bus.load, 1);
    chk("start_busy", bus.busy, 1);
    chk("start_addr", bus.load_address, 0);
  endtask

  task automatic run_vector(input vec_t v);
    int ld;
    int p;
    int ov;
    fill_sb();
    start_pulse();
    ld = 0;
    while (bus.load && ld < 300) begin
      bus.sample_valid = v.toggle ? ((ld % 2) == 1) : 1'b1;
      ld++;
      step();
    end
    bus.sample_valid = 1'b0;
    chk("load_cycles", ld, v.exp_load_cycles);
    chk("proc_entry_rd", bus.rd_valid, 1);
    chk("proc_entry_level", bus.fft_level, 0);
    chk("proc_entry_iter", bus.butterfly_iter, 0);
    p = 0;
    while (!bus.out_valid && p < 1000) begin
      bus.start = (v.start_mid && bus.processing && bus.fft_level == 6'd3) ? 1'b1 : 1'b0;
      p++;
      step();
    end
    bus.start = 1'b0;
    chk("latency", p, v.exp_lat);
    ov = 0;
    while (bus.out_valid && ov < 200) begin
      ov++;
      step();
    end
    chk("out_valid_cycles", ov, 64);
    chk("fft_done_pulses", n_done, 1);
    chk("end_busy", bus.busy, 0);
    chk("end_load", bus.load, 0);
    chk("end_processing", bus.processing, 0);
    chk("end_done", bus.done, 0);
    chk("bank_log_len", bank_log.size(), 6);
    for (int i = 0; i < bank_log.size() && i < 6; i++) chk("bank_seq", bank_log[i], i % 2);
    chk("left_load", exp_load.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_out", exp_out.size(), 0);
    chk("left_wr", wr_q.size(), 0);
  endtask

  initial begin
    int k;
    vectors[0] = '{toggle: 1'b0, start_mid: 1'b0, exp_load_cycles: 64,  exp_lat: 6 * (32 + LAT) + 1};
    vectors[1] = '{toggle: 1'b1, start_mid: 1'b0, exp_load_cycles: 128, exp_lat: 6 * (32 + LAT) + 1};
    vectors[2] = '{toggle: 1'b0, start_mid: 1'b1, exp_load_cycles: 64,  exp_lat: 6 * (32 + LAT) + 1};

    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    repeat (3) step();
    check_all_zero("idle");

    for (int i = 0; i < 3; i++) run_vector(vectors[i]);

    // Asynchronous reset in the middle of level 2.
    fill_sb();
    start_pulse();
    bus.sample_valid = 1'b1;
    k = 0;
    while (!(bus.processing && bus.fft_level == 6'd2 && bus.butterfly_iter == 6'd10) && k < 1000) begin
      k++;
      step();
    end
    bus.sample_valid = 1'b0;
    chk("reach_level2", int'(bus.fft_level), 2);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    flush_sb();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("post_reset_wr_en", bus.wr_en, 0);
      chk("post_reset_busy", bus.busy, 0);
    end

    run_vector(vectors[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got %0d expected 0 (simulation time limit)", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
- Top-level sequencer for the 64-point radix-2 in-place FFT: walks the design through LOAD -> PROCESS (6 levels x 32 butterflies) -> OUTPUT.
- Drives the address generator's control inputs (load, processing, done, fft_level, butterfly_iter, load_address, out_address).
- Delays read-side indices through a write-back pipeline matching butterfly latency, producing write enables and write-side indices for the two ping-pong RAM banks.

Parameters:
- BFLY_LAT, 2, cycles from butterfly read-address issue to write-back (RAM read + butterfly pipeline); legal 1..7.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin new transform; sampled only in IDLE
- sample_valid  in  1  input sample present this cycle (LOAD only)
- load  out  1  LOAD state active
- processing  out  1  PROC or DRAIN state active
- done  out  1  OUT state active
- busy  out  1  any state other than IDLE
- load_address  out  6  natural-order sample index; AGU bit-reverses it
- load_we  out  1  = load & sample_valid; write strobe to bank 0
- fft_level  out  6  current read-side level, 0..5
- butterfly_iter  out  6  current read-side butterfly index, 0..31
- rd_valid  out  1  butterfly read issued this cycle
- wr_fft_level  out  6  fft_level delayed BFLY_LAT cycles
- wr_butterfly_iter  out  6  butterfly_iter delayed BFLY_LAT cycles
- wr_en  out  1  rd_valid delayed BFLY_LAT cycles; butterfly write-back strobe
- bank_sel  out  1  = fft_level[0]; 0: read bank 0 / write bank 1, 1: read bank 1 / write bank 0
- wr_bank_sel  out  1  = wr_fft_level[0]
- out_address  out  6  output read index, natural order
- out_valid  out  1  output data valid (one cycle after out_address, for synchronous RAM)
- fft_done  out  1  single-cycle pulse after the last output word

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; every output and all counters and pipeline stages = 0. Reset mid-operation aborts immediately; no partial writes after release.
- States: IDLE, LOAD, PROC, DRAIN, OUT.
- IDLE: start=1 -> LOAD with load_address=0. start in any other state is ignored.
- LOAD: load=1.
  - Each cycle with sample_valid=1: load_we=1 and load_address increments.
  - sample_valid=0 stalls; address holds, load_we=0.
  - Accepting address 63 -> PROC with fft_level=0, butterfly_iter=0.
- PROC: rd_valid=1 every cycle; butterfly_iter increments 0..31. After issuing iter 31 -> DRAIN; iter resets to 0.
- DRAIN: rd_valid=0 for exactly BFLY_LAT cycles. This guarantees all writes of level L land before level L+1 reads.
  - At drain end with fft_level<5: fft_level++ and return to PROC.
  - At drain end with fft_level=5: -> OUT with out_address=0.
- Write pipeline: BFLY_LAT-deep shift of {rd_valid, fft_level, butterfly_iter}.
  - Feeds wr_en, wr_fft_level and wr_butterfly_iter; runs in all states.
  - wr_en never asserts outside PROC/DRAIN.
- Banks: LOAD writes bank 0. After level 5 (odd, bank_sel=1) the result resides in bank 0, which OUT reads.
- OUT: done=1; out_address increments every cycle 0..63 (no backpressure).
  - out_valid is registered from "address presented last cycle", so it is high for exactly 64 cycles, lagging out_address by 1.
  - The cycle after out_address=63: -> IDLE, fft_done=1 for one cycle; the final out_valid coincides with it.
- Counter widths are 6 bits and never wrap; terminal values force the state transition.
- Total latency from last load to first out_valid: 6*(32+BFLY_LAT)+1 cycles (BFLY_LAT=2: 205).

Decomposition:
- Package fft_pkg:
  - State enum fft_state_t {IDLE, LOAD, PROC, DRAIN, OUT}.
  - Constants: FFT_LOG2N=6, FFT_N=64, N_BFLY=32, LAST_LEVEL=5.
- Sub-module delay_line (parameter WIDTH, DEPTH; async active-low reset to 0) implements the BFLY_LAT write-back pipeline for the 13-bit {valid, level, iter} bundle.

Test Plan:
- Reset then start=1 with continuous sample_valid -> load_we high 64 cycles, load_address 0..63; PROC begins the next cycle with fft_level=0, iter=0.
- sample_valid toggled 1/0 during LOAD -> address advances only on valid cycles; exactly 64 load_we pulses; LOAD lasts 128 cycles.
- BFLY_LAT=2 full run -> per level 32 rd_valid, then 2 idle; wr_en matches rd_valid delayed 2 with matching wr_iter/wr_level; no rd_valid of level L+1 before last wr_en of level L; bank_sel sequence 0,1,0,1,0,1.
- OUT phase -> out_address 0..63, out_valid 64 cycles lagging by 1; fft_done single pulse; back to IDLE; busy falls.
- start asserted during PROC level 3 -> no effect; sequence completes normally.
- reset_n pulled low mid-level 2 (asynchronously, not on an edge) -> all outputs 0 immediately; after release, IDLE and no wr_en until a new start.
